// File: rtl/tx_pkg.sv
// Shared definitions for the TX symbol path: 4-ASK levels, Gray symbol map and PRBS-9 source.
// The level values are the same codes the matched filter's coefficient lookup decodes.
package tx_pkg;

  localparam int unsigned SPS_DEFAULT = 4;
  localparam int unsigned XW          = 18;
  localparam int unsigned SYM_W       = 2;

  // 1s17 levels: -131072, -43691, +43691, +131071
  localparam logic signed [XW-1:0] LVL_M3 = 18'sh20000;
  localparam logic signed [XW-1:0] LVL_M1 = 18'sh35555;
  localparam logic signed [XW-1:0] LVL_P1 = 18'sh0AAAB;
  localparam logic signed [XW-1:0] LVL_P3 = 18'sh1FFFF;

  typedef enum logic [SYM_W-1:0] {
    SymM3 = 2'b00,
    SymM1 = 2'b01,
    SymP3 = 2'b10,
    SymP1 = 2'b11
  } gray_sym_e;

  localparam int unsigned       PRBS_W            = 9;
  localparam int unsigned       PRBS_TAP_HI       = 8;
  localparam int unsigned       PRBS_TAP_LO       = 4;
  localparam logic [PRBS_W-1:0] PRBS_SEED_DEFAULT = 9'h1FF;

  function automatic logic signed [XW-1:0] gray_to_level(input logic [SYM_W-1:0] sym);
    logic signed [XW-1:0] level;
    unique case (gray_sym_e'(sym))
      SymM3:   level = LVL_M3;
      SymM1:   level = LVL_M1;
      SymP1:   level = LVL_P1;
      SymP3:   level = LVL_P3;
      default: level = '0;
    endcase
    return level;
  endfunction

  function automatic logic [PRBS_W-1:0] prbs9_step(input logic [PRBS_W-1:0] state);
    return {state[PRBS_W-2:0], state[PRBS_TAP_HI] ^ state[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Small synchronous FIFO for buffered input symbols; head word is visible on rdata_o
// whenever empty_o is low (no write-to-read bypass).
module sym_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned     Aw      = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [Aw:0]     FullCnt = (Aw + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wptr_q, wptr_d;
  logic [Aw-1:0]    rptr_q, rptr_d;
  logic [Aw:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Depth is a power of two, so the pointers wrap on their own.
  always_comb begin
    wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = do_pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/tx_sym_upsampler.sv
// 4-ASK symbol mapper and zero-stuffing upsampler feeding the TX matched filter.
// Symbols come from a valid/ready FIFO or an internal PRBS-9; one registered sample per clk.
module tx_sym_upsampler
  import tx_pkg::*;
#(
  parameter int unsigned       SPS        = SPS_DEFAULT,
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter logic [PRBS_W-1:0] PRBS_SEED  = PRBS_SEED_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SYM_W-1:0]     sym_in,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic                 prbs_en,
  input  logic                 clr_underrun,
  output logic signed [XW-1:0] x_out,
  output logic                 sym_strobe,
  output logic                 underrun
);

  localparam int unsigned    PhW       = $clog2(SPS);
  localparam logic [PhW-1:0] LastPhase = PhW'(SPS - 1);

  logic [PhW-1:0]       phase_q, phase_d;
  logic                 slot;
  logic [PRBS_W-1:0]    lfsr_q, lfsr_d;
  logic signed [XW-1:0] x_q, x_d;
  logic                 strobe_q, strobe_d;
  logic                 underrun_q, underrun_d;
  logic                 underrun_set;

  logic                 fifo_push, fifo_pop;
  logic                 fifo_full, fifo_empty;
  logic [SYM_W-1:0]     fifo_rdata;

  sym_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (SYM_W)
  ) u_sym_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (sym_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign slot      = (phase_q == '0);
  assign sym_ready = !fifo_full && !prbs_en && !reset;
  assign fifo_push = sym_valid && sym_ready;
  // The FIFO is frozen while the PRBS source owns the slot.
  assign fifo_pop  = slot && !prbs_en && !fifo_empty;

  always_comb begin
    phase_d = (phase_q == LastPhase) ? '0 : phase_q + 1'b1;
  end

  // prbs_en only matters on slot cycles, so a mode switch never splits a symbol period.
  always_comb begin
    x_d          = '0;
    strobe_d     = 1'b0;
    underrun_set = 1'b0;
    lfsr_d       = lfsr_q;
    if (slot) begin
      if (prbs_en) begin
        x_d      = gray_to_level(lfsr_q[SYM_W-1:0]);
        strobe_d = 1'b1;
        lfsr_d   = prbs9_step(prbs9_step(lfsr_q));
      end else if (!fifo_empty) begin
        x_d      = gray_to_level(fifo_rdata);
        strobe_d = 1'b1;
      end else begin
        underrun_set = 1'b1;
      end
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    if (underrun_set) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      lfsr_q     <= PRBS_SEED;
      x_q        <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      lfsr_q     <= lfsr_d;
      x_q        <= x_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign x_out      = x_q;
  assign sym_strobe = strobe_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_tx_sym_upsampler.sv
// Directed bench for tx_sym_upsampler (SPS=4, FIFO_DEPTH=2, PRBS_SEED=9'h1FF).
// Inputs change and outputs are sampled on the falling edge.
module tb_tx_sym_upsampler;

  // -131072, -43691, +43691, +131071
  localparam logic signed [17:0] L_M3 = 18'sh20000;
  localparam logic signed [17:0] L_M1 = 18'sh35555;
  localparam logic signed [17:0] L_P1 = 18'sh0AAAB;
  localparam logic signed [17:0] L_P3 = 18'sh1FFFF;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [1:0]         sym_in = 2'b00;
  logic               sym_valid = 1'b0;
  logic               sym_ready;
  logic               prbs_en = 1'b0;
  logic               clr_underrun = 1'b0;
  logic signed [17:0] x_out;
  logic               sym_strobe;
  logic               underrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tx_sym_upsampler #(
    .SPS        (4),
    .FIFO_DEPTH (2),
    .PRBS_SEED  (9'h1FF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sym_in       (sym_in),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .prbs_en      (prbs_en),
    .clr_underrun (clr_underrun),
    .x_out        (x_out),
    .sym_strobe   (sym_strobe),
    .underrun     (underrun)
  );

  function automatic logic signed [17:0] lvl(input logic [1:0] s);
    case (s)
      2'b00:   return L_M3;
      2'b01:   return L_M1;
      2'b11:   return L_P1;
      default: return L_P3;
    endcase
  endfunction

  // Drive one cycle's inputs, note whether the handshake fires, advance to the next falling edge.
  task automatic drive(input logic v, input logic [1:0] s, input logic clr, output logic acc);
    sym_valid    = v;
    sym_in       = s;
    clr_underrun = clr;
    #1;
    acc = v && sym_ready;
    @(negedge clk);
  endtask

  // Leaves the bench at the start of cycle 0 (first cycle with reset low).
  task automatic do_reset(input logic prbs);
    @(negedge clk);
    reset        = 1'b1;
    prbs_en      = prbs;
    sym_valid    = 1'b0;
    clr_underrun = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic acc;
    @(negedge clk);
    reset     = 1'b1;
    prbs_en   = 1'b0;
    sym_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (sym_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got %b want 0", sym_ready);
    end
    total++;
    if (x_out !== 18'sd0 || sym_strobe !== 1'b0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got x=%0d strobe=%b ur=%b want 0 0 0",
               x_out, sym_strobe, underrun);
    end
    reset = 1'b0;
    #1;
    total++;
    if (sym_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", sym_ready);
    end
    drive(1'b0, 2'b00, 1'b0, acc);
    total++;
    if (underrun !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_slot: got ur=%b want 1", underrun);
    end
  endtask

  task automatic test_map();
    logic [1:0]         q[$];
    logic               acc, exp_acc;
    logic signed [17:0] exp_x;
    do_reset(1'b0);
    q = '{2'b00, 2'b01, 2'b11, 2'b10};
    for (int n = 0; n < 20; n++) begin
      drive(q.size() > 0, (q.size() > 0) ? q[0] : 2'b00, n == 1, acc);
      exp_acc = (n == 0) || (n == 1) || (n == 5) || (n == 9);
      total++;
      if (acc !== exp_acc) begin
        bad++;
        $display("FAIL map_accept cyc %0d: got %b want %b", n, acc, exp_acc);
      end
      if (acc) void'(q.pop_front());
      case (n + 1)
        5:       exp_x = L_M3;
        9:       exp_x = L_M1;
        13:      exp_x = L_P1;
        17:      exp_x = L_P3;
        default: exp_x = 18'sd0;
      endcase
      total++;
      if (x_out !== exp_x || sym_strobe !== (exp_x != 18'sd0)) begin
        bad++;
        $display("FAIL map_sample cyc %0d: got x=%0d strobe=%b want x=%0d strobe=%b",
                 n + 1, x_out, sym_strobe, exp_x, exp_x != 18'sd0);
      end
      total++;
      if (underrun !== (n == 0)) begin
        bad++;
        $display("FAIL map_underrun cyc %0d: got %b want %b", n + 1, underrun, n == 0);
      end
    end
  endtask

  task automatic test_underrun();
    logic acc;
    logic exp_ur [10];
    exp_ur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset(1'b0);
    for (int n = 0; n < 10; n++) begin
      drive(1'b0, 2'b00, (n == 2) || (n == 8) || (n == 9), acc);
      total++;
      if (underrun !== exp_ur[n] || x_out !== 18'sd0 || sym_strobe !== 1'b0) begin
        bad++;
        $display("FAIL underrun cyc %0d: got ur=%b x=%0d strobe=%b want ur=%b x=0 strobe=0",
                 n + 1, underrun, x_out, sym_strobe, exp_ur[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] src[$];
    logic [1:0] sb[$];
    logic [1:0] s;
    logic       acc, exp_rdy;
    int         emitted;
    int         n;
    do_reset(1'b0);
    for (int i = 0; i < 100; i++) begin
      s = 2'((i * 3) + (i / 4));
      src.push_back(s);
    end
    emitted = 0;
    n = 0;
    while (n < 460 && emitted < 100) begin
      drive(src.size() > 0, (src.size() > 0) ? src[0] : 2'b00, n == 1, acc);
      if (n <= 393) begin
        exp_rdy = (n < 2) || (n % 4 == 1);
        total++;
        if (acc !== exp_rdy) begin
          bad++;
          $display("FAIL b2b_ready cyc %0d: got %b want %b", n, acc, exp_rdy);
        end
      end
      if (acc) sb.push_back(src.pop_front());
      if (sym_strobe === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra cyc %0d: got strobe with x=%0d want no strobe", n + 1, x_out);
        end else begin
          s = sb.pop_front();
          if (x_out !== lvl(s)) begin
            bad++;
            $display("FAIL b2b_data sym %0d: got %0d want %0d", emitted, x_out, lvl(s));
          end
        end
        emitted++;
      end else begin
        total++;
        if (x_out !== 18'sd0) begin
          bad++;
          $display("FAIL b2b_zero cyc %0d: got %0d want 0", n + 1, x_out);
        end
      end
      if (n + 1 >= 2 && n + 1 <= 404) begin
        total++;
        if (underrun !== 1'b0) begin
          bad++;
          $display("FAIL b2b_underrun cyc %0d: got %b want 0", n + 1, underrun);
        end
      end
      n++;
    end
    total++;
    if (emitted != 100 || sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got emitted=%0d pending=%0d want 100 0", emitted, sb.size());
    end
  endtask

  task automatic test_prbs();
    logic signed [17:0] p [5];
    logic               acc;
    int                 m, s, rdy_err, ur_err, zero_err;
    p = '{L_P1, L_M3, L_M3, L_M1, L_P1};
    rdy_err  = 0;
    ur_err   = 0;
    zero_err = 0;
    do_reset(1'b1);
    for (int n = 0; n < 2064; n++) begin
      drive(1'b1, 2'b01, 1'b0, acc);
      if (acc) rdy_err++;
      if (underrun !== 1'b0) ur_err++;
      m = n + 1;
      if (m % 4 == 1) begin
        s = m / 4;
        if (s < 5 || (s >= 511 && s < 516)) begin
          total++;
          if (x_out !== p[s % 511] || sym_strobe !== 1'b1) begin
            bad++;
            $display("FAIL prbs_slot %0d: got x=%0d strobe=%b want x=%0d strobe=1",
                     s, x_out, sym_strobe, p[s % 511]);
          end
        end
      end else if (x_out !== 18'sd0 || sym_strobe !== 1'b0) begin
        zero_err++;
      end
    end
    total++;
    if (rdy_err != 0) begin
      bad++;
      $display("FAIL prbs_ready: got %0d accepted cycles want 0", rdy_err);
    end
    total++;
    if (ur_err != 0) begin
      bad++;
      $display("FAIL prbs_underrun: got %0d cycles with underrun want 0", ur_err);
    end
    total++;
    if (zero_err != 0) begin
      bad++;
      $display("FAIL prbs_stuff: got %0d non-zero stuffed samples want 0", zero_err);
    end
    prbs_en = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic               acc;
    logic signed [17:0] exp_x;
    do_reset(1'b0);
    drive(1'b1, 2'b10, 1'b0, acc);
    drive(1'b1, 2'b11, 1'b0, acc);
    #1;
    total++;
    if (sym_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_full: got ready=%b want 0", sym_ready);
    end
    reset     = 1'b1;
    sym_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (x_out !== 18'sd0 || underrun !== 1'b0 || sym_strobe !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got x=%0d ur=%b strobe=%b want 0 0 0", x_out, underrun, sym_strobe);
    end
    for (int n = 0; n < 12; n++) begin
      drive(n == 1, 2'b10, 1'b0, acc);
      if (n == 1) begin
        total++;
        if (acc !== 1'b1) begin
          bad++;
          $display("FAIL mid_push: got %b want 1", acc);
        end
      end
      exp_x = (n + 1 == 5) ? L_P3 : 18'sd0;
      total++;
      if (x_out !== exp_x || sym_strobe !== (n + 1 == 5)) begin
        bad++;
        $display("FAIL mid_sample cyc %0d: got x=%0d strobe=%b want x=%0d strobe=%b",
                 n + 1, x_out, sym_strobe, exp_x, n + 1 == 5);
      end
      if (n == 0) begin
        total++;
        if (underrun !== 1'b1) begin
          bad++;
          $display("FAIL mid_discard: got ur=%b want 1", underrun);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_map();
    test_underrun();
    test_back_to_back();
    test_prbs();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion want finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/tx_sym_upsampler.md
Name: tx_sym_upsampler

Overview:
TX front-end stage that feeds the 4-ASK pulse-shaping matched filter.
- Accepts 2-bit symbols over a valid/ready handshake, or generates them from an internal PRBS-9 source.
- Maps each symbol to a 4-ASK level in 1s17 and zero-stuffs by SPS, producing one sample per clk.
- Output values exactly match the levels the filter's coefficient lookup decodes.

Parameters:
SPS, 4, samples per symbol (upsampling factor), legal range 2..16
FIFO_DEPTH, 2, input symbol buffer depth (power of 2)
PRBS_SEED, 9'h1FF, LFSR value loaded on reset (must be non-zero)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
sym_in  in  2  Gray-coded input symbol
sym_valid  in  1  sym_in valid
sym_ready  out  1  block can accept a symbol (FIFO not full and prbs_en=0)
prbs_en  in  1  1 = internal PRBS-9 source, 0 = external sym_in
clr_underrun  in  1  clears the underrun sticky flag
x_out  out  18  signed 1s17 upsampled sample, to filter x_in
sym_strobe  out  1  high on the cycle x_out carries a symbol (not a stuffed zero)
underrun  out  1  sticky: a symbol slot found the FIFO empty in external mode

Behaviour:
- Reset (synchronous, active-high) sets:
  - x_out=0, sym_strobe=0, underrun=0
  - phase counter=0, FIFO empty, LFSR=PRBS_SEED
  - sym_ready=0 during reset.
- Level map (Gray coding):
  - 00 -> -18'sd131072
  - 01 -> -18'sd43691
  - 11 -> +18'sd43691
  - 10 -> +18'sd131071
- Phase counter counts 0..SPS-1 every clk after reset and wraps to 0.
- Symbol slot = cycle with phase==0:
  - External mode: if FIFO is non-empty, pop it; at that edge x_out<=mapped level and sym_strobe<=1.
  - External mode, FIFO empty: x_out<=0, sym_strobe<=0, underrun<=1.
- Non-slot cycles (phase!=0): x_out<=0, sym_strobe<=0.
- Output is registered: the sample decided in a cycle appears one clk later.
- Handshake:
  - Push occurs when sym_valid && sym_ready at a clk edge.
  - sym_valid=1 with sym_ready=0 is held by the source and not lost.
- FIFO has no bypass. A push and a slot at the same edge on an empty FIFO yields an underrun for that slot; the symbol is emitted at the next slot.
- Simultaneous push and pop on a non-full FIFO: both occur and occupancy is unchanged.
- sym_ready is combinational from registered state: !full && !prbs_en && !reset.
- PRBS mode (prbs_en=1):
  - At each slot, symbol = lfsr[1:0].
  - The LFSR then advances two steps: new = lfsr[8]^lfsr[4]; lfsr <= {lfsr[7:0], new}.
  - sym_ready=0; FIFO contents are retained and not popped; underrun is never set.
- prbs_en is sampled only at slot cycles, so a mode change never splits a symbol period.
- underrun:
  - Cleared by clr_underrun at the next edge.
  - If a set condition and clr_underrun occur at the same edge, set wins.
- Reset mid-operation discards FIFO contents and any partial symbol period. The first slot after reset release is the first cycle with reset=0.

Decomposition:
- Shared package tx_pkg: SPS default, 4-ASK level constants (LVL_M3, LVL_M1, LVL_P1, LVL_P3), Gray-to-level map function, PRBS-9 taps/seed.
- One sub-module, sym_fifo: FIFO_DEPTH x 2-bit synchronous FIFO with full/empty flags.
- LFSR, phase counter and map stay in the top.

Test Plan:
- Push 00,01,11,10 back-to-back after reset (SPS=4) -> x_out = -131072,0,0,0,-43691,0,0,0,+43691,0,0,0,+131071,0,0,0; sym_strobe high on each non-zero sample; underrun stays 0 when the first push precedes the first slot.
- No symbols supplied after reset -> x_out stays 0, sym_strobe=0, underrun=1 from the first slot; pulse clr_underrun -> underrun back to 0 next clk.
- Hold sym_valid=1 continuously -> sym_ready drops after 2 accepted symbols and re-asserts 1 clk after each slot pop; no symbol is lost or duplicated over 100 symbols (scoreboard compare).
- prbs_en=1 from reset, PRBS_SEED=9'h1FF -> first two slot samples +43691 (sym 11), then -131072 (sym 00); sequence period is 511 LFSR steps; sym_ready=0 throughout.
- Assert reset for 1 clk mid-stream with the FIFO holding 2 symbols -> x_out=0 and underrun=0 the next clk; the buffered symbols never appear; the new symbol period starts at phase 0.
- Loop x_out into the matched filter with an isolated single symbol 10 -> the filter's output impulse response equals its coefficient column b[7][*] scaled, confirming the level encoding matches the filter lookup.
